// File: rtl/iomem_timer.sv
// Down-counting timer on the iomem bus with a prescaler, auto-reload and a level irq.
// Every access in the 256-byte window is acknowledged one cycle later; a back-to-back access waits one extra cycle.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_COUNT    = 6'h02;
    localparam logic [5:0] OFF_RELOAD   = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;

    logic                  en, auto_reload, irq_en, expired;
    logic [PRESCALE_W-1:0] prescale, pcnt, prescale_wr;
    logic [31:0]           count, reload, count_wr, reload_wr, rd_mux, pre_ext;
    logic                  sel, accept, wr, tick, expire;
    logic [5:0]            off;
    logic                  unused_addr;

    assign unused_addr = ^iomem_addr[1:0];

    assign sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign accept = sel && !iomem_ready;
    assign wr     = accept && (iomem_wstrb != 4'b0000);
    assign off    = iomem_addr[7:2];
    assign tick   = en && (pcnt == prescale);
    assign expire = tick && (count == 32'd0);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        pre_ext = '0;
        pre_ext[PRESCALE_W-1:0] = prescale;
        for (int i = 0; i < PRESCALE_W; i++)
            prescale_wr[i] = iomem_wstrb[i/8] ? iomem_wdata[i] : prescale[i];
        count_wr  = merge(count, iomem_wdata, iomem_wstrb);
        reload_wr = merge(reload, iomem_wdata, iomem_wstrb);
    end

    // Read data reflects register state before any update at this edge.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:     rd_mux = {29'd0, irq_en, auto_reload, en};
            OFF_PRESCALE: rd_mux = pre_ext;
            OFF_COUNT:    rd_mux = count;
            OFF_RELOAD:   rd_mux = reload;
            OFF_STATUS:   rd_mux = {31'd0, expired};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            expired     <= 1'b0;
            prescale    <= '0;
            pcnt        <= '0;
            count       <= '0;
            reload      <= '0;
        end else begin
            iomem_ready <= accept;
            iomem_rdata <= accept ? rd_mux : 32'd0;
            irq         <= expired & irq_en;

            if (!en || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESCALE_W'(1);

            // One-shot stop; a same-cycle CTRL write below overrides it.
            if (expire && !auto_reload)
                en <= 1'b0;
            if (wr && off == OFF_CTRL && iomem_wstrb[0])
                {irq_en, auto_reload, en} <= iomem_wdata[2:0];

            if (wr && off == OFF_PRESCALE)
                prescale <= prescale_wr;
            if (wr && off == OFF_RELOAD)
                reload <= reload_wr;

            // A bus write to COUNT discards that cycle's tick update entirely.
            if (wr && off == OFF_COUNT)
                count <= count_wr;
            else if (tick)
                count <= (count != 32'd0) ? count - 32'd1 : (auto_reload ? reload : 32'd0);

            if (expire)
                expired <= 1'b1;
            else if (wr && off == OFF_STATUS && iomem_wstrb[0] && iomem_wdata[0])
                expired <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iomem_timer.sv
// Directed bench for iomem_timer: bus protocol, register access, prescaler/counter timing, collisions, reset.
module tb_iomem_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    iomem_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        output logic [31:0] rd, output logic got);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        got = 1'b0;
        rd  = '0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (iomem_ready) begin
                got = 1'b1;
                rd  = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
    endtask

    task automatic wr_reg(input string tag, input logic [7:0] off, input logic [3:0] strb,
                          input logic [31:0] wd);
        logic [31:0] rd;
        logic        got;
        xfer(BASE + {24'd0, off}, strb, wd, rd, got);
        chk({tag, "_ack"}, {31'd0, got}, 32'd1);
    endtask

    task automatic rd_reg(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        got;
        xfer(BASE + {24'd0, off}, 4'b0000, 32'd0, rd, got);
        chk({tag, "_ack"}, {31'd0, got}, 32'd1);
        chk(tag, rd, exp);
    endtask

    logic [31:0] cnt_exp [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    initial begin
        logic [31:0] rd;
        logic        got;

        reset = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = '0;
        iomem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            rd_reg("rst_reg", 8'(4 * i), 32'd0);
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, iomem_ready}, 32'd0);

        // Byte strobes, hole in the window, outside the window.
        wr_reg("reload_wr", 8'h0C, 4'b0011, 32'hAABB_CCDD);
        rd_reg("reload_strb", 8'h0C, 32'h0000_CCDD);
        rd_reg("hole_read", 8'h20, 32'd0);
        xfer(BASE + 32'h100, 4'b0000, 32'd0, rd, got);
        chk("outside_no_ack", {31'd0, got}, 32'd0);
        chk("outside_rdata", iomem_rdata, 32'd0);

        // One-shot with irq: expired four edges after en, irq one edge later.
        wr_reg("os_pre", 8'h04, 4'b1111, 32'd0);
        wr_reg("os_cnt", 8'h08, 4'b1111, 32'd3);
        wr_reg("os_ctrl", 8'h00, 4'b1111, 32'h5);
        repeat (4) @(negedge clk);
        chk("os_irq_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("os_irq_rise", {31'd0, irq}, 32'd1);
        rd_reg("os_count", 8'h08, 32'd0);
        rd_reg("os_ctrl_en_clr", 8'h00, 32'h4);
        rd_reg("os_status", 8'h10, 32'd1);
        wr_reg("os_clr", 8'h10, 4'b0001, 32'd1);
        chk("os_irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("os_irq_fall", {31'd0, irq}, 32'd0);
        rd_reg("os_status_clr", 8'h10, 32'd0);

        // Auto-reload with PRESCALE=2: count 1,0,1,0 at 3-cycle steps.
        wr_reg("ar_pre", 8'h04, 4'b1111, 32'd2);
        wr_reg("ar_rel", 8'h0C, 4'b1111, 32'd1);
        wr_reg("ar_cnt", 8'h08, 4'b1111, 32'd1);
        wr_reg("ar_ctrl", 8'h00, 4'b1111, 32'h3);
        for (int k = 0; k < 12; k++) begin
            chk("ar_count", dut.count, cnt_exp[k]);
            chk("ar_expired", {31'd0, dut.expired}, (k >= 6) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        wr_reg("ar_stop", 8'h00, 4'b1111, 32'h0);
        wr_reg("ar_clr", 8'h10, 4'b0001, 32'd1);

        // STATUS clear lands on the expiry cycle: expiry wins.
        wr_reg("cc_pre", 8'h04, 4'b1111, 32'd0);
        wr_reg("cc_cnt", 8'h08, 4'b1111, 32'd3);
        wr_reg("cc_ctrl", 8'h00, 4'b1111, 32'h1);
        repeat (3) @(negedge clk);
        wr_reg("cc_clr", 8'h10, 4'b0001, 32'd1);
        rd_reg("cc_status", 8'h10, 32'd1);
        wr_reg("cc_clr2", 8'h10, 4'b0001, 32'd1);

        // COUNT write on a tick cycle: the write wins.
        wr_reg("cw_pre", 8'h04, 4'b1111, 32'd3);
        wr_reg("cw_cnt", 8'h08, 4'b1111, 32'h50);
        wr_reg("cw_ctrl", 8'h00, 4'b1111, 32'h1);
        repeat (3) @(negedge clk);
        wr_reg("cw_cnt_tick", 8'h08, 4'b1111, 32'h10);
        rd_reg("cw_count", 8'h08, 32'h10);
        wr_reg("cw_stop", 8'h00, 4'b1111, 32'h0);

        // Continuous valid: ready 0,1,0,1; reset during ready clears everything.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE;
        iomem_wstrb = 4'b0000;
        chk("hold_ready0", {31'd0, iomem_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready1", {31'd0, iomem_ready}, 32'd1);
        @(negedge clk);
        chk("hold_ready2", {31'd0, iomem_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready3", {31'd0, iomem_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        iomem_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            rd_reg("rst2_reg", 8'(4 * i), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped down-counting timer that acts as a responder on the SoC `iomem` bus. Decodes a 256-byte window, acknowledges every access in the window with a single-cycle registered `iomem_ready`, and drives a level interrupt intended for one of the `irq_5`..`irq_7` inputs. Several instances may share the bus. Each one drives `iomem_ready` and `iomem_rdata` only for its own window, and the top level ORs them together.

## Interface
- `BASE_ADDR`, default `32'h0300_0000`: window base; bits [7:0] must be zero.
- `PRESCALE_W`, default 16: prescaler register width, 1..32.
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high reset.
- `iomem_valid`  in  1: initiator request; held with stable addr/wdata/wstrb until ready.
- `iomem_ready`  out  1: one-cycle acknowledge.
- `iomem_wstrb`  in  4: byte write enables; 0 means read.
- `iomem_addr`  in  32: byte address.
- `iomem_wdata`  in  32: write data.
- `iomem_rdata`  out  32: read data; zero whenever `iomem_ready` is low.
- `irq`  out  1: level interrupt = `status.expired & ctrl.irq_en`.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8]`.
- Register map, by offset `addr[7:2]`:
  - 0x00 CTRL: bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`; other bits read 0.
  - 0x04 PRESCALE: `[PRESCALE_W-1:0]`.
  - 0x08 COUNT: 32-bit current count.
  - 0x0C RELOAD: 32-bit reload value.
  - 0x10 STATUS: bit0 `expired`; write-1-to-clear.
- Other offsets in the window read 0, ignore writes, and are still acknowledged. `addr[1:0]` is ignored.
- Writes honour `iomem_wstrb` per byte. STATUS clear uses `wstrb[0] & wdata[0]`.
- Prescaler:
  - `pcnt` counts 0..PRESCALE while `en`=1.
  - `tick` asserts on the cycle `pcnt == PRESCALE`; `pcnt` then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - `en`=0 holds `pcnt` at 0.
- Counter on `tick`:
  - COUNT != 0: COUNT decrements.
  - COUNT == 0: `expired` is set.
  - COUNT == 0 with `auto_reload`=1: COUNT <= RELOAD.
  - COUNT == 0 with `auto_reload`=0: COUNT stays 0 and `en` clears.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same cycle: the write wins for the written bytes; the tick's decrement/reload is discarded that cycle, and `expired` is still set if COUNT was 0.
  - STATUS clear and expiry in the same cycle: `expired` ends set.
  - CTRL write and hardware clear of `en` in the same cycle: the bus write wins.
- Reset: all registers, `pcnt`, `iomem_ready`, `iomem_rdata` and `irq` go to 0.

## Timing
- Access accepted in cycle T when `sel` and `!iomem_ready`.
  - Write takes effect at the edge ending T.
  - `iomem_ready`=1 and `iomem_rdata` valid in T+1, for exactly one cycle.
- In T+1 (ready high) a new acceptance is blocked, even if `iomem_valid` is still high. A back-to-back request is therefore accepted at T+2 at the earliest, giving 2-cycle throughput.
- Read data is sampled at the edge ending T: it reflects register state before any same-cycle tick update.
- Initiator dropping `iomem_valid` early (protocol violation): a pending ready still fires once; no state is corrupted.
- `reset` in T+1: `iomem_ready` is forced low in T+2; a write accepted in T is discarded by reset.
- `irq` is registered: it rises one cycle after the `expired` set edge and falls one cycle after the clear.
- Unselected addresses: `iomem_ready` and `iomem_rdata` stay 0.

## Test plan
- Reset, then read all five registers -> each read returns 0, `iomem_ready` pulses one cycle at T+1, `irq`=0.
- Write RELOAD with wstrb=4'b0011, data 0xAABBCCDD -> readback 0x0000CCDD; a read at BASE+0x20 -> 0 and is acknowledged; a read at BASE+0x100 -> no ready.
- PRESCALE=0, COUNT=3, CTRL=0x5 (one-shot, irq_en) -> `expired` set 4 cycles after `en`, `irq` high one cycle later, COUNT=0, CTRL.en reads 0; write STATUS=1 -> `irq` low.
- PRESCALE=2, RELOAD=1, COUNT=1, CTRL=0x3 -> `expired` pulses set every 6 cycles; COUNT sequence 1,0,1,0 at 3-cycle steps.
- Force STATUS clear in the exact expiry cycle -> `expired` reads 1; force a COUNT write of 0x10 on a tick cycle -> COUNT reads 0x10.
- Hold `iomem_valid` high continuously on CTRL reads -> ready pattern 0,1,0,1; assert `reset` during ready -> ready 0 next cycle, all registers 0.
